// File: rtl/muldiv_wb_arbiter.sv
// Writeback port arbiter between the non-stallable multiplier and the iterative divider.
// Redirect-younger results are killed; a starvation FSM throttles multiplier issue.
module muldiv_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int PREG_W       = 6,
  parameter int ROB_W        = 5,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mul_valid,
  input  logic              mul_we,
  input  logic [PREG_W-1:0] mul_rd,
  input  logic [ROB_W:0]    mul_rob,
  input  logic [DATA_W-1:0] mul_data,
  input  logic              div_valid,
  output logic              div_ready,
  input  logic              div_we,
  input  logic [PREG_W-1:0] div_rd,
  input  logic [ROB_W:0]    div_rob,
  input  logic [DATA_W-1:0] div_data,
  input  logic              redirect,
  input  logic [ROB_W:0]    redirect_idx,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [PREG_W-1:0] wb_rd,
  output logic [ROB_W:0]    wb_rob,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_src,
  output logic              mul_issue_block
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BLOCK = 2'd2
  } state_t;

  // The MSB flips on each ROB wrap, so a differing MSB inverts the index compare.
  function automatic logic older(input logic [ROB_W:0] a, input logic [ROB_W:0] b);
    logic res;
    if (a[ROB_W] == b[ROB_W]) res = (a[ROB_W-1:0] < b[ROB_W-1:0]);
    else                      res = (a[ROB_W-1:0] > b[ROB_W-1:0]);
    return res;
  endfunction

  logic kill_mul_p0;
  logic kill_div_p0;
  logic mul_live_p0;
  logic div_live_p0;
  logic div_blocked_p0;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // Stage p0: flush and arbitration, all combinational
  assign kill_mul_p0    = redirect & ~older(mul_rob, redirect_idx);
  assign kill_div_p0    = redirect & ~older(div_rob, redirect_idx);
  assign mul_live_p0    = mul_valid & ~kill_mul_p0;
  assign div_live_p0    = div_valid & ~kill_div_p0;
  assign div_ready      = div_valid & (kill_div_p0 | ~mul_live_p0);
  assign div_blocked_p0 = div_valid & ~div_ready;

  // Stage p1: registered writeback port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_rd    <= '0;
      wb_rob   <= '0;
      wb_data  <= '0;
      wb_src   <= 1'b0;
    end else begin
      wb_valid <= mul_live_p0 | div_live_p0;
      if (mul_live_p0) begin
        wb_we   <= mul_we;
        wb_rd   <= mul_rd;
        wb_rob  <= mul_rob;
        wb_data <= mul_data;
        wb_src  <= 1'b0;
      end else if (div_live_p0) begin
        wb_we   <= div_we;
        wb_rd   <= div_rd;
        wb_rob  <= div_rob;
        wb_data <= div_data;
        wb_src  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        if (div_blocked_p0) begin
          state_next = (STARVE_LIMIT == 1) ? ST_BLOCK : ST_WAIT;
          cnt_next   = CNT_ONE;
        end
      end
      ST_WAIT: begin
        if (!div_blocked_p0) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt == LIMIT_M1) begin
          state_next = ST_BLOCK;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      ST_BLOCK: begin
        if (!div_blocked_p0) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Pure state decode keeps the throttle glitch-free and clears on async reset.
  assign mul_issue_block = (state == ST_BLOCK);

endmodule

// File: doc/muldiv_wb_arbiter.md
Name: muldiv_wb_arbiter

Overview:
- Shares one integer writeback port between the fixed-latency multiplier pipeline and the iterative divider.
- The multiplier cannot stall, so it has priority. The divider holds its result under a valid/ready handshake until it is granted.
- A starvation FSM throttles multiplier issue when the divider has waited too long.
- Branch redirects kill in-flight results younger than the redirect point, before writeback.

Parameters:
DATA_W, 32, writeback data width
PREG_W, 6, physical register index width
ROB_W, 5, ROB index width; robIdx ports carry ROB_W+1 bits (MSB = wrap/direction bit)
STARVE_LIMIT, 8, consecutive blocked divider cycles before issue throttling (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
mul_valid  in  1  multiplier result valid this cycle (non-stallable)
mul_we  in  1  multiplier result writes a register
mul_rd  in  PREG_W  multiplier destination preg
mul_rob  in  ROB_W+1  multiplier robIdx
mul_data  in  DATA_W  multiplier result
div_valid  in  1  divider result pending
div_ready  out  1  divider result consumed (granted or flushed)
div_we  in  1  divider result writes a register
div_rd  in  PREG_W  divider destination preg
div_rob  in  ROB_W+1  divider robIdx
div_data  in  DATA_W  divider result
redirect  in  1  backend redirect this cycle
redirect_idx  in  ROB_W+1  robIdx of redirecting instruction
wb_valid  out  1  writeback valid (registered)
wb_we  out  1  writeback register write enable
wb_rd  out  PREG_W  writeback preg
wb_rob  out  ROB_W+1  writeback robIdx
wb_data  out  DATA_W  writeback data
wb_src  out  1  source of current writeback: 0 = mul, 1 = div
mul_issue_block  out  1  tells issue to stop dispatching multiplies (registered)

Behaviour:
- Reset (rst=0, asynchronous):
  - wb_valid, wb_we, wb_rd, wb_rob, wb_data, wb_src and mul_issue_block are 0.
  - FSM is IDLE; wait counter is 0.
  - A pending divider handshake is abandoned; the divider is reset too.
- Age compare older(a,b):
  - Same MSB: a[ROB_W-1:0] < b[ROB_W-1:0].
  - Different MSB: a[ROB_W-1:0] > b[ROB_W-1:0].
- Flush rule: kill_x = redirect & ~older(x_rob, redirect_idx). An entry equal to redirect_idx is killed.
- Combinational arbitration (comb = combinational):
  - mul_live = mul_valid & ~kill_mul.
  - div_live = div_valid & ~kill_div.
  - div_ready = div_valid & (kill_div | ~mul_live). A killed multiplier slot is reused by the divider in the same cycle.
- Output register, 1-cycle latency:
  - Load mul fields when mul_live, with wb_src=0.
  - Else load div fields when div_live, with wb_src=1.
  - Else wb_valid=0.
  - wb_valid is never retracted once asserted. Redirects arriving in the output cycle are handled downstream.
- Starvation FSM and wait counter (width clog2(STARVE_LIMIT+1)):
  - IDLE:
    - div_valid & ~div_ready -> WAIT, with cnt=1.
  - WAIT:
    - div_ready or ~div_valid -> IDLE, with cnt=0.
    - Blocked again and cnt==STARVE_LIMIT-1 -> BLOCK.
    - Otherwise cnt++.
  - BLOCK:
    - mul_issue_block=1 (a state decode of a registered flop).
    - div_ready or ~div_valid -> IDLE; mul_issue_block drops the next cycle.
  - Already-issued multiplies still drain with priority while in BLOCK.
  - STARVE_LIMIT=1 enters BLOCK after the first blocked cycle.
- Simultaneous events:
  - mul and div both live: mul wins.
  - div killed while mul live: div_ready=1 and the div result is dropped.
  - Both killed: wb_valid=0 next cycle; div_ready=1.
- No buffering inside the block. The divider must hold all div_* fields stable while div_valid & ~div_ready.

Test Plan:
1. Multiplier only: mul_valid=1, mul_rd=5, mul_rob={0,4}, mul_data=0x1234 at cycle t -> at t+1: wb_valid=1, wb_rd=5, wb_data=0x1234, wb_src=0; at t+2: wb_valid=0.
2. Collision, STARVE_LIMIT=8: mul and div valid at t, div_data=0xBEEF -> div_ready=0 at t, mul written back at t+1. mul idle at t+1 -> div_ready=1 at t+1, wb_data=0xBEEF with wb_src=1 at t+2. FSM goes WAIT at t+1, IDLE at t+2.
3. Starvation, STARVE_LIMIT=8: mul_valid=1 continuously, div_valid=1 from t0 -> mul_issue_block=1 from t8. Drop mul_valid at t10 -> div_ready=1 at t10, div writeback at t11, mul_issue_block=0 at t11.
4. Flush with wrap, in one cycle: redirect_idx={0,30}, mul_rob={1,2} (younger), div_rob={0,29} (older) -> mul killed, div_ready=1, div written back next cycle. Repeat with div_rob={0,31} -> div_ready=1, wb_valid=0.
5. Equal index: redirect_idx={1,7}, mul_rob={1,7}, div_valid=0 -> wb_valid=0 next cycle.
6. Reset mid-BLOCK: drive the FSM into BLOCK, then assert rst=0 mid-cycle -> mul_issue_block and wb_valid go 0 immediately, without waiting for a clock edge. After release with div_valid=0: state IDLE, cnt=0.
